tri_bus_arbiter: RTL

- Shares one tri-state output bus (WIDTH pins driven through SB_IO cells: D_OUT_0 = bus_dout, OUTPUT_ENABLE = bus_oe) among N_REQ internal requesters.
- Grants the bus round-robin and passes words with a per-cycle ready/req handshake.
- Inserts a guaranteed high-Z turnaround gap between owners so no two drivers, on-board or chained, overlap.
- Sits between the core result/status sources and the pad ring.

---
 rtl/tri_arb_pkg.sv | 25 ++
 rtl/tri_bus_arbiter_rr_picker.sv | 29 ++
 rtl/tri_bus_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tri_arb_pkg.sv
// Shared encodings, counter widths and helpers for the tri-state bus arbiter.
// The TRI_ARB_TIMEOUT_EN build uses HOLD_W for its per-grant hold counter.
package tri_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        XFER = ST_XFER,
        TURN = ST_TURN
    } arb_state_t;

    localparam int TCNT_W = 4;
    localparam int HOLD_W = 8;

    function automatic logic [7:0] onehot(input logic [2:0] idx, input int n);
        logic [7:0] v;
        v = '0;
        if (int'(idx) < n) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_picker.sv
// Combinational round-robin select: first set request after ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] winner
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        winner  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                winner  = w_idx;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state pad bus with a forced high-Z turnaround.
// Define TRI_ARB_TIMEOUT_EN to revoke grants held MAX_HOLD XFER cycles without last.
//   state | meaning
//   IDLE  | bus released, picking the next owner
//   XFER  | owner moves one word per cycle while req is high
//   TURN  | final word shown, then TURNAROUND high-Z cycles
module tri_bus_arbiter
    import tri_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2,
    parameter int MAX_HOLD   = 64
) (
    input  logic                   hwclk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    input  logic [N_REQ-1:0]       last,
    output logic [N_REQ-1:0]       ready,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       bus_dout,
    output logic                   bus_oe,
    output logic                   busy,
    output logic                   timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TURNAROUND < 0 || TURNAROUND > 15 ||
        MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("tri_bus_arbiter: parameter out of range");
    end

    arb_state_t        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  r_grant;
    logic [WIDTH-1:0]  r_dout;
    logic              r_oe;
    logic [TCNT_W-1:0] r_tcnt;

    logic              w_any;
    logic [PTR_W-1:0]  w_winner;
    logic [7:0]        w_onehot;
    logic              w_sel_req;
    logic              w_done;
    logic              w_force;
    logic [WIDTH-1:0]  w_data;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    // r_ptr always equals the owner index while in XFER
    assign w_onehot  = onehot(3'(w_winner), N_REQ);
    assign w_sel_req = |(req & r_grant);
    assign w_done    = w_sel_req & (|(last & r_grant));
    assign w_data    = data[r_ptr*WIDTH +: WIDTH];

`ifdef TRI_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;
    logic [HOLD_W-1:0] w_hold_next;

    assign w_hold_next = r_hold + HOLD_W'(1);
    assign w_force     = (r_state == XFER) && !w_done && (w_hold_next == HOLD_W'(MAX_HOLD));
    assign timeout     = r_timeout;

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == XFER) r_hold <= w_hold_next;
            else                 r_hold <= '0;
        end
    end
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= PTR_W'(N_REQ - 1);
            r_grant <= '0;
            r_dout  <= '0;
            r_oe    <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_oe <= 1'b0;
                    if (w_any) begin
                        r_grant <= w_onehot[N_REQ-1:0];
                        r_ptr   <= w_winner;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_sel_req) begin
                        r_dout <= w_data;
                        r_oe   <= 1'b1;
                    end else begin
                        r_oe   <= 1'b0;
                    end
                    if (w_done || w_force) begin
                        r_grant <= '0;
                        r_tcnt  <= TCNT_W'(TURNAROUND);
                        r_state <= TURN;
                    end
                end
                TURN: begin
                    r_oe <= 1'b0;
                    if (r_tcnt == '0) r_state <= IDLE;
                    else              r_tcnt  <= r_tcnt - TCNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready    = (r_state == XFER) ? r_grant : '0;
    assign grant    = r_grant;
    assign bus_dout = r_dout;
    assign bus_oe   = r_oe;
    assign busy     = (r_state != IDLE);

endmodule
